// File: rtl/lcd_pkg.sv
// Shared constants, types and the per-segment decay step for the LCD deflicker scheduler.
package lcd_pkg;

  localparam int unsigned MAX_X_SEGMENT     = 9;
  localparam int unsigned MAX_Y_SEGMENT     = 16;
  localparam int unsigned MAX_Z_SEGMENT     = 4;
  localparam int unsigned DECAY_MAX         = 31;
  localparam int unsigned DECAY_MIN_DISPLAY = 16;
  localparam int unsigned N_SEGMENTS        = MAX_X_SEGMENT * MAX_Y_SEGMENT * MAX_Z_SEGMENT;
  localparam int unsigned IDX_W             = 10;
  localparam int unsigned DECAY_W           = 5;

  typedef logic [IDX_W-1:0]   seg_idx_t;
  typedef logic [DECAY_W-1:0] decay_t;

  localparam seg_idx_t LAST_IDX = seg_idx_t'(N_SEGMENTS - 1);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    SWEEP = 2'd2
  } sched_state_t;

  typedef struct packed {
    decay_t next_d;
    logic   disp;
  } decay_step_t;

  // Saturating step; the display bit is taken from the old value so the display lags one tick.
  function automatic decay_step_t decay_step(decay_t d, logic raw);
    decay_step_t r;
    r.next_d = d;
    if (raw && (d < decay_t'(DECAY_MAX))) begin
      r.next_d = d + decay_t'(1);
    end else if (!raw && (d != decay_t'(0))) begin
      r.next_d = d - decay_t'(1);
    end
    r.disp = (d > decay_t'(DECAY_MIN_DISPLAY));
    return r;
  endfunction

endpackage

// File: rtl/lcd_decay_scheduler.sv
// Sweeps all segments through a shared decay RAM on each deflicker tick and fills the
// back bank of a double-buffered display RAM; banks swap on vblank once a sweep completes.
module lcd_decay_scheduler
  import lcd_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         divider_1khz,
  input  logic         vblank_int,
  output logic [9:0]   raw_addr,
  input  logic         raw_bit,
  output logic [9:0]   decay_rd_addr,
  input  logic [4:0]   decay_rd_data,
  output logic         decay_wr_en,
  output logic [9:0]   decay_wr_addr,
  output logic [4:0]   decay_wr_data,
  output logic         disp_wr_en,
  output logic         disp_wr_bank,
  output logic [9:0]   disp_wr_addr,
  output logic         disp_wr_data,
  output logic         display_bank,
  output logic         busy,
  output logic         overrun
);

  sched_state_t state_q, state_d;
  seg_idx_t     idx_q, idx_d;
  seg_idx_t     wr_addr_q, wr_addr_d;
  logic         div_q, vb_q;
  logic         tick_pending_q, tick_pending_d;
  logic         swap_pending_q, swap_pending_d;
  logic         overrun_q, overrun_d;
  logic         display_bank_q, display_bank_d;
  logic         raw_q, raw_d;
  logic         wr_vld_q, wr_vld_d;
  logic         wr_init_q, wr_init_d;
  logic         wr_bank_q, wr_bank_d;
  logic         busy_q, busy_d;
  logic         div_rise, vb_rise, sweep_start, last_write;
  decay_step_t  step_r;

  assign div_rise   = divider_1khz & ~div_q;
  assign vb_rise    = vblank_int & ~vb_q;
  assign last_write = wr_vld_q & ~wr_init_q & (wr_addr_q == LAST_IDX);

  // Next-state: index sequencing, S0->S1 pipeline, tick and bank bookkeeping.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    wr_addr_d      = wr_addr_q;
    wr_bank_d      = wr_bank_q;
    wr_vld_d       = 1'b0;
    wr_init_d      = 1'b0;
    raw_d          = raw_q;
    tick_pending_d = tick_pending_q;
    swap_pending_d = swap_pending_q;
    overrun_d      = overrun_q;
    display_bank_d = display_bank_q;
    sweep_start    = 1'b0;

    case (state_q)
      INIT: begin
        wr_vld_d  = 1'b1;
        wr_init_d = 1'b1;
        wr_addr_d = idx_q;
        wr_bank_d = 1'b0;
        if (idx_q == LAST_IDX) begin
          idx_d   = seg_idx_t'(0);
          state_d = IDLE;
        end else begin
          idx_d = idx_q + seg_idx_t'(1);
        end
      end
      IDLE: begin
        if (tick_pending_q) begin
          sweep_start = 1'b1;
          idx_d       = seg_idx_t'(0);
          state_d     = SWEEP;
        end
      end
      SWEEP: begin
        raw_d     = raw_bit;
        wr_vld_d  = 1'b1;
        wr_addr_d = idx_q;
        wr_bank_d = ~display_bank_q;
        if (idx_q == LAST_IDX) begin
          idx_d   = seg_idx_t'(0);
          state_d = IDLE;
        end else begin
          idx_d = idx_q + seg_idx_t'(1);
        end
      end
      default: begin
        idx_d   = seg_idx_t'(0);
        state_d = INIT;
      end
    endcase

    if (sweep_start) tick_pending_d = 1'b0;
    if (div_rise) begin
      if (tick_pending_q && !sweep_start) overrun_d = 1'b1;
      tick_pending_d = 1'b1;
    end

    // A swap needs a finished sweep and a quiet pipeline; vblank edges are not queued.
    if (last_write) begin
      swap_pending_d = 1'b1;
    end else if (vb_rise && swap_pending_q && (state_q == IDLE) && !wr_vld_q) begin
      display_bank_d = ~display_bank_q;
      swap_pending_d = 1'b0;
    end

    busy_d = (state_d != IDLE) | wr_vld_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= INIT;
      idx_q          <= seg_idx_t'(0);
      wr_addr_q      <= seg_idx_t'(0);
      wr_bank_q      <= 1'b0;
      wr_vld_q       <= 1'b0;
      wr_init_q      <= 1'b0;
      raw_q          <= 1'b0;
      div_q          <= 1'b0;
      vb_q           <= 1'b0;
      tick_pending_q <= 1'b0;
      swap_pending_q <= 1'b0;
      overrun_q      <= 1'b0;
      display_bank_q <= 1'b0;
      busy_q         <= 1'b1;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      wr_addr_q      <= wr_addr_d;
      wr_bank_q      <= wr_bank_d;
      wr_vld_q       <= wr_vld_d;
      wr_init_q      <= wr_init_d;
      raw_q          <= raw_d;
      div_q          <= divider_1khz;
      vb_q           <= vblank_int;
      tick_pending_q <= tick_pending_d;
      swap_pending_q <= swap_pending_d;
      overrun_q      <= overrun_d;
      display_bank_q <= display_bank_d;
      busy_q         <= busy_d;
    end
  end

  // S1 write data follows the RAM read port directly, which is valid one cycle after S0.
  assign step_r        = decay_step(decay_rd_data, raw_q);
  assign raw_addr      = idx_q;
  assign decay_rd_addr = idx_q;
  assign decay_wr_en   = wr_vld_q;
  assign decay_wr_addr = wr_addr_q;
  assign decay_wr_data = (wr_vld_q & ~wr_init_q) ? step_r.next_d : decay_t'(0);
  assign disp_wr_en    = wr_vld_q;
  assign disp_wr_bank  = wr_bank_q;
  assign disp_wr_addr  = wr_addr_q;
  assign disp_wr_data  = wr_vld_q & ~wr_init_q & step_r.disp;
  assign display_bank  = display_bank_q;
  assign busy          = busy_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_lcd_decay_scheduler.sv
// Directed bench for lcd_decay_scheduler with behavioural decay and display RAMs.
module tb_lcd_decay_scheduler;

  logic       clk, reset, divider_1khz, vblank_int, raw_bit;
  logic [9:0] raw_addr, decay_rd_addr, decay_wr_addr, disp_wr_addr;
  logic [4:0] decay_rd_data, decay_wr_data;
  logic       decay_wr_en, disp_wr_en, disp_wr_bank, disp_wr_data;
  logic       display_bank, busy, overrun;

  int checks = 0;
  int errors = 0;
  int raw_mode = 0;

  logic [4:0] dmem [0:575];
  logic       pmem0 [0:575];
  logic       pmem1 [0:575];
  logic [4:0] rd_next;
  int dec_wr_cnt = 0, dec_nz_cnt = 0, sweep_mark = 0;
  int b0_cnt = 0, b1_cnt = 0, disp_other_cnt = 0;

  lcd_decay_scheduler dut (
    .clk(clk), .reset(reset), .divider_1khz(divider_1khz), .vblank_int(vblank_int),
    .raw_addr(raw_addr), .raw_bit(raw_bit),
    .decay_rd_addr(decay_rd_addr), .decay_rd_data(decay_rd_data),
    .decay_wr_en(decay_wr_en), .decay_wr_addr(decay_wr_addr), .decay_wr_data(decay_wr_data),
    .disp_wr_en(disp_wr_en), .disp_wr_bank(disp_wr_bank), .disp_wr_addr(disp_wr_addr),
    .disp_wr_data(disp_wr_data), .display_bank(display_bank), .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: all segments off, 1: only segment 37 on, 2: all segments on
  always_comb begin
    raw_bit = 1'b0;
    if (raw_mode == 2) raw_bit = 1'b1;
    else if (raw_mode == 1) raw_bit = (raw_addr == 10'd37);
  end

  // RAM models: writes committed mid-cycle, registered read.
  always @(negedge clk) begin
    if (decay_wr_en === 1'b1 && decay_wr_addr < 10'd576) begin
      dmem[decay_wr_addr] = decay_wr_data;
      dec_wr_cnt++;
      if (decay_wr_data != 5'd0) dec_nz_cnt++;
      if (decay_wr_addr == 10'd0) sweep_mark++;
    end
    if (disp_wr_en === 1'b1 && disp_wr_addr < 10'd576) begin
      if (disp_wr_bank) begin pmem1[disp_wr_addr] = disp_wr_data; b1_cnt++; end
      else begin pmem0[disp_wr_addr] = disp_wr_data; b0_cnt++; end
      if (disp_wr_data && disp_wr_addr != 10'd37) disp_other_cnt++;
    end
    rd_next = (decay_rd_addr < 10'd576) ? dmem[decay_rd_addr] : 5'd0;
  end

  always @(posedge clk) decay_rd_data <= rd_next;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input logic level, input int bound, input string name);
    int n = 0;
    while (busy !== level && n < bound) begin step(); n++; end
    checks++;
    if (busy !== level) begin
      errors++;
      $display("FAIL %s: busy=%b required %b within %0d cycles", name, busy, level, bound);
    end
  endtask

  task automatic run_tick(input string name);
    divider_1khz = 1'b1; step(); step();
    divider_1khz = 1'b0;
    wait_busy(1'b1, 10, name);
    wait_busy(1'b0, 700, name);
  endtask

  task automatic pulse_vblank();
    vblank_int = 1'b1; step();
    vblank_int = 1'b0; step();
  endtask

  task automatic test_reset();
    int c0, nz0, b00, b10, bc, n, nz;
    reset = 1'b1; divider_1khz = 1'b0; vblank_int = 1'b0; raw_mode = 0;
    step(); step(); step();
    checks++;
    if (decay_wr_en !== 1'b0 || disp_wr_en !== 1'b0 || raw_addr !== 10'd0 || decay_wr_addr !== 10'd0) begin
      errors++;
      $display("FAIL reset_strobes: wr_en=%b/%b raw_addr=%0d wr_addr=%0d required 0/0/0/0",
               decay_wr_en, disp_wr_en, raw_addr, decay_wr_addr);
    end
    checks++;
    if (display_bank !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: display_bank=%b overrun=%b required 0/0", display_bank, overrun);
    end
    c0 = dec_wr_cnt; nz0 = dec_nz_cnt; b00 = b0_cnt; b10 = b1_cnt;
    reset = 1'b0;
    bc = 0; n = 0;
    step();
    while (busy === 1'b1 && n < 2000) begin bc++; n++; step(); end
    checks++;
    if (bc != 576) begin errors++; $display("FAIL init_busy_cycles: got %0d required 576", bc); end
    checks++;
    if (dec_wr_cnt - c0 != 576 || dec_nz_cnt - nz0 != 0) begin
      errors++;
      $display("FAIL init_decay_writes: got %0d (%0d nonzero) required 576 (0)", dec_wr_cnt - c0, dec_nz_cnt - nz0);
    end
    checks++;
    if (b0_cnt - b00 != 576 || b1_cnt - b10 != 0) begin
      errors++;
      $display("FAIL init_disp_writes: bank0=%0d bank1=%0d required 576/0", b0_cnt - b00, b1_cnt - b10);
    end
    nz = 0;
    for (int i = 0; i < 576; i++) if (dmem[i] !== 5'd0 || pmem0[i] !== 1'b0) nz++;
    checks++;
    if (nz != 0) begin errors++; $display("FAIL init_clear: %0d entries not cleared, required 0", nz); end
    checks++;
    if (busy !== 1'b0 || display_bank !== 1'b0) begin
      errors++;
      $display("FAIL init_done: busy=%b display_bank=%b required 0/0", busy, display_bank);
    end
  endtask

  task automatic test_decay_ramp();
    int o0 = disp_other_cnt;
    raw_mode = 1;
    for (int k = 1; k <= 18; k++) begin
      run_tick("ramp_tick");
      checks++;
      if (dmem[37] !== 5'(k)) begin
        errors++; $display("FAIL ramp_decay tick %0d: got %0d required %0d", k, dmem[37], k);
      end
      checks++;
      if (pmem1[37] !== (k >= 18)) begin
        errors++; $display("FAIL ramp_disp tick %0d: got %b required %b", k, pmem1[37], (k >= 18));
      end
    end
    checks++;
    if (dmem[36] !== 5'd0 || dmem[38] !== 5'd0 || dmem[575] !== 5'd0) begin
      errors++;
      $display("FAIL ramp_neighbours: d36=%0d d38=%0d d575=%0d required 0", dmem[36], dmem[38], dmem[575]);
    end
    checks++;
    if (disp_other_cnt != o0) begin
      errors++; $display("FAIL ramp_other_disp: %0d lit bits elsewhere, required 0", disp_other_cnt - o0);
    end
  endtask

  task automatic test_saturation();
    raw_mode = 2;
    for (int k = 0; k < 40; k++) run_tick("sat_tick");
    checks++;
    if (dmem[0] !== 5'd31 || dmem[37] !== 5'd31 || dmem[575] !== 5'd31) begin
      errors++;
      $display("FAIL sat_ceiling: d0=%0d d37=%0d d575=%0d required 31", dmem[0], dmem[37], dmem[575]);
    end
    checks++;
    if (pmem1[575] !== 1'b1) begin errors++; $display("FAIL sat_disp: got %b required 1", pmem1[575]); end
    raw_mode = 0;
    for (int j = 1; j <= 16; j++) begin
      run_tick("fall_tick");
      checks++;
      if (dmem[575] !== 5'(31 - j)) begin
        errors++; $display("FAIL fall_decay tick %0d: got %0d required %0d", j, dmem[575], 31 - j);
      end
      checks++;
      if (pmem1[575] !== (j <= 15)) begin
        errors++; $display("FAIL fall_disp tick %0d: got %b required %b", j, pmem1[575], (j <= 15));
      end
    end
  endtask

  task automatic test_overrun();
    int s0 = sweep_mark;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_pre: got %b required 0", overrun); end
    divider_1khz = 1'b1; step(); step(); divider_1khz = 1'b0;
    wait_busy(1'b1, 10, "overrun_start");
    for (int e = 0; e < 2; e++) begin
      repeat (50) step();
      divider_1khz = 1'b1; step(); divider_1khz = 1'b0; step();
    end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b required 1", overrun); end
    wait_busy(1'b0, 1500, "overrun_done");
    repeat (20) step();
    checks++;
    if (sweep_mark - s0 != 2 || busy !== 1'b0) begin
      errors++; $display("FAIL overrun_sweeps: got %0d sweeps busy=%b required 2/0", sweep_mark - s0, busy);
    end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b required 1", overrun); end
  endtask

  task automatic test_vblank();
    int b1s = b1_cnt;
    divider_1khz = 1'b1; step(); step(); divider_1khz = 1'b0;
    wait_busy(1'b1, 10, "vblank_start");
    repeat (100) step();
    pulse_vblank();
    checks++;
    if (display_bank !== 1'b0) begin errors++; $display("FAIL vblank_in_sweep: got %b required 0", display_bank); end
    wait_busy(1'b0, 700, "vblank_done");
    repeat (5) step();
    checks++;
    if (display_bank !== 1'b0 || b1_cnt - b1s != 576) begin
      errors++;
      $display("FAIL vblank_after_sweep: bank=%b bank1 writes=%0d required 0/576", display_bank, b1_cnt - b1s);
    end
    pulse_vblank();
    checks++;
    if (display_bank !== 1'b1) begin errors++; $display("FAIL vblank_swap: got %b required 1", display_bank); end
    repeat (5) step();
    pulse_vblank();
    checks++;
    if (display_bank !== 1'b1) begin errors++; $display("FAIL vblank_no_resweep: got %b required 1", display_bank); end
  endtask

  task automatic test_reset_mid_sweep();
    int n = 0;
    int nz = 0;
    raw_mode = 2;
    divider_1khz = 1'b1; step(); step(); divider_1khz = 1'b0;
    while (!(busy === 1'b1 && raw_addr === 10'd300) && n < 700) begin step(); n++; end
    checks++;
    if (raw_addr !== 10'd300) begin errors++; $display("FAIL midsweep_reach: raw_addr=%0d required 300", raw_addr); end
    reset = 1'b1; step();
    checks++;
    if (decay_wr_en !== 1'b0 || disp_wr_en !== 1'b0 || raw_addr !== 10'd0) begin
      errors++;
      $display("FAIL midsweep_strobes: wr_en=%b/%b raw_addr=%0d required 0/0/0", decay_wr_en, disp_wr_en, raw_addr);
    end
    checks++;
    if (display_bank !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL midsweep_flags: bank=%b overrun=%b required 0/0", display_bank, overrun);
    end
    reset = 1'b0; step();
    checks++;
    if (decay_wr_en !== 1'b1 || decay_wr_addr !== 10'd0 || decay_wr_data !== 5'd0 || disp_wr_bank !== 1'b0) begin
      errors++;
      $display("FAIL midsweep_init_first: en=%b addr=%0d data=%0d bank=%b required 1/0/0/0",
               decay_wr_en, decay_wr_addr, decay_wr_data, disp_wr_bank);
    end
    wait_busy(1'b0, 700, "midsweep_init_done");
    for (int i = 0; i < 576; i++) if (dmem[i] !== 5'd0) nz++;
    checks++;
    if (nz != 0) begin errors++; $display("FAIL midsweep_clear: %0d nonzero decay entries, required 0", nz); end
  endtask

  task automatic test_vblank_last_write();
    int n = 0;
    raw_mode = 1;
    divider_1khz = 1'b1; step(); step(); divider_1khz = 1'b0;
    while (!(decay_wr_en === 1'b1 && decay_wr_addr === 10'd575) && n < 700) begin step(); n++; end
    checks++;
    if (decay_wr_addr !== 10'd575) begin errors++; $display("FAIL lastwr_reach: addr=%0d required 575", decay_wr_addr); end
    pulse_vblank();
    checks++;
    if (display_bank !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL lastwr_vblank: bank=%b busy=%b required 0/0", display_bank, busy);
    end
    repeat (3) step();
    pulse_vblank();
    checks++;
    if (display_bank !== 1'b1) begin errors++; $display("FAIL lastwr_next_vblank: got %b required 1", display_bank); end
    checks++;
    if (dmem[37] !== 5'd1 || pmem1[37] !== 1'b0) begin
      errors++; $display("FAIL lastwr_data: d37=%0d disp=%b required 1/0", dmem[37], pmem1[37]);
    end
  endtask

  initial begin
    reset = 1'b1; divider_1khz = 1'b0; vblank_int = 1'b0; rd_next = 5'd0;
    for (int i = 0; i < 576; i++) begin dmem[i] = 5'h1f; pmem0[i] = 1'b1; pmem1[i] = 1'b1; end
    test_reset();
    test_decay_ramp();
    test_saturation();
    test_overrun();
    test_vblank();
    test_reset_mid_sweep();
    test_vblank_last_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
